// File: rtl/window_gen.sv
// Sliding-window generator: shifts incoming pixel columns into a KERNEL_LENGTH^2 window
// and emits one window per valid column position, with row/frame-last flags.
module window_gen #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned KERNEL_LENGTH = 3,
   parameter int unsigned IMG_WIDTH     = 128,
   parameter int unsigned IMG_HEIGHT    = 128
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            in_valid,
   output logic                                            in_ready,
   input  logic [KERNEL_LENGTH*DATA_WIDTH-1:0]             in_col,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output logic [KERNEL_LENGTH*KERNEL_LENGTH*DATA_WIDTH-1:0] out_win,
   output logic                                            out_row_last,
   output logic                                            out_frame_last
);

   localparam int unsigned WinW = KERNEL_LENGTH * KERNEL_LENGTH * DATA_WIDTH;
   localparam int unsigned CntW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [CntW-1:0] ColLast     = CntW'(IMG_WIDTH - 1);
   localparam logic [CntW-1:0] ColFirstWin = CntW'(KERNEL_LENGTH - 1);
   localparam logic [RowW-1:0] RowLast     = RowW'(IMG_HEIGHT - KERNEL_LENGTH);

   logic [WinW-1:0] shift_q, shift_d;
   logic [WinW-1:0] win_q, win_d;
   logic [CntW-1:0] col_cnt_q, col_cnt_d;
   logic [RowW-1:0] row_cnt_q, row_cnt_d;
   logic            valid_q, valid_d;
   logic            row_last_q, row_last_d;
   logic            frame_last_q, frame_last_d;
   logic            accept, win_load, col_wrap;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign win_load = accept && (col_cnt_q >= ColFirstWin);
   assign col_wrap = (col_cnt_q == ColLast);

   // Left shift by one column; the newest column lands at c = KERNEL_LENGTH-1 with
   // the oldest buffered row (top slice) going to r = 0.
   always_comb begin
      shift_d = shift_q;
      if (accept) begin
         for (int r = 0; r < KERNEL_LENGTH; r++) begin
            for (int c = 0; c < KERNEL_LENGTH; c++) begin
               if (c < KERNEL_LENGTH - 1) begin
                  shift_d[(r*KERNEL_LENGTH+c)*DATA_WIDTH +: DATA_WIDTH] =
                     shift_q[(r*KERNEL_LENGTH+c+1)*DATA_WIDTH +: DATA_WIDTH];
               end else begin
                  shift_d[(r*KERNEL_LENGTH+c)*DATA_WIDTH +: DATA_WIDTH] =
                     in_col[(KERNEL_LENGTH-1-r)*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

   always_comb begin
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      if (accept) begin
         if (col_wrap) begin
            col_cnt_d = '0;
            row_cnt_d = (row_cnt_q == RowLast) ? '0 : row_cnt_q + RowW'(1);
         end else begin
            col_cnt_d = col_cnt_q + CntW'(1);
         end
      end
   end

   // A new window wins over a transfer so back-to-back windows keep out_valid high.
   always_comb begin
      win_d        = win_q;
      valid_d      = valid_q;
      row_last_d   = row_last_q;
      frame_last_d = frame_last_q;
      if (win_load) begin
         win_d        = shift_d;
         valid_d      = 1'b1;
         row_last_d   = col_wrap;
         frame_last_d = col_wrap && (row_cnt_q == RowLast);
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q      <= '0;
         win_q        <= '0;
         col_cnt_q    <= '0;
         row_cnt_q    <= '0;
         valid_q      <= 1'b0;
         row_last_q   <= 1'b0;
         frame_last_q <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         win_q        <= win_d;
         col_cnt_q    <= col_cnt_d;
         row_cnt_q    <= row_cnt_d;
         valid_q      <= valid_d;
         row_last_q   <= row_last_d;
         frame_last_q <= frame_last_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_win        = win_q;
   assign out_row_last   = row_last_q;
   assign out_frame_last = frame_last_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed and randomized-handshake bench for window_gen with K=3, W=8, H=5; expected
// windows come from a direct {row, col, slice} formula, not from a shift-register copy.
module tb_window_gen;

   localparam int unsigned Dw   = 32;
   localparam int unsigned K    = 3;
   localparam int unsigned W    = 8;
   localparam int unsigned H    = 5;
   localparam int unsigned WinW = K * K * Dw;
   localparam int unsigned ColW = K * Dw;
   localparam int unsigned WinsPerFrame = (W - K + 1) * (H - K + 1);

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [ColW-1:0] in_col;
   logic            out_valid;
   logic            out_ready;
   logic [WinW-1:0] out_win;
   logic            out_row_last;
   logic            out_frame_last;

   window_gen #(
      .DATA_WIDTH   (Dw),
      .KERNEL_LENGTH(K),
      .IMG_WIDTH    (W),
      .IMG_HEIGHT   (H)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_col        (in_col),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_win       (out_win),
      .out_row_last  (out_row_last),
      .out_frame_last(out_frame_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Golden model state
   int              m_col = 0;
   int              m_row = 0;
   logic            exp_valid = 1'b0;
   logic [WinW-1:0] exp_win = '0;
   logic            exp_rl = 1'b0;
   logic            exp_fl = 1'b0;
   int              n_accepts = 0;
   int              win_cnt = 0;

   task automatic check(input string tag, input logic [WinW-1:0] got,
                        input logic [WinW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [Dw-1:0] pix(input int row, input int col, input int slice);
      return Dw'({8'(row), 8'(col), 8'(slice)});
   endfunction

   function automatic logic [ColW-1:0] col_value(input int row, input int col);
      logic [ColW-1:0] v;
      for (int s = 0; s < K; s++) v[s*Dw +: Dw] = pix(row, col, s);
      return v;
   endfunction

   // Window whose rightmost column is column p of feed row fr.
   function automatic logic [WinW-1:0] win_value(input int fr, input int p);
      logic [WinW-1:0] v;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            v[(r*K+c)*Dw +: Dw] = pix(fr, p - (K - 1) + c, K - 1 - r);
      return v;
   endfunction

   task automatic step(input logic iv, input logic ordy);
      logic acc, xf;
      @(negedge clk);
      in_valid  = iv;
      in_col    = col_value(m_row, m_col);
      out_ready = ordy;
      #1;
      check("out_valid", WinW'(out_valid), WinW'(exp_valid));
      check("in_ready", WinW'(in_ready), WinW'(!exp_valid || ordy));
      if (exp_valid) begin
         check("out_win", out_win, exp_win);
         check("row_last", WinW'(out_row_last), WinW'(exp_rl));
         check("frame_last", WinW'(out_frame_last), WinW'(exp_fl));
      end
      acc = iv && (!exp_valid || ordy);
      xf  = exp_valid && ordy;
      if (xf) begin
         win_cnt++;
         if (exp_fl) begin
            check("wins_per_frame", WinW'(win_cnt), WinW'(WinsPerFrame));
            win_cnt = 0;
         end
      end
      if (acc) begin
         n_accepts++;
         if (m_col >= K - 1) begin
            exp_valid = 1'b1;
            exp_win   = win_value(m_row, m_col);
            exp_rl    = (m_col == W - 1);
            exp_fl    = exp_rl && (m_row == H - K);
         end else if (xf) begin
            exp_valid = 1'b0;
         end
         if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - K) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end else if (xf) begin
         exp_valid = 1'b0;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_out_valid", WinW'(out_valid), '0);
      check("rst_in_ready", WinW'(in_ready), WinW'(1));
      check("rst_out_win", out_win, '0);
      check("rst_row_last", WinW'(out_row_last), '0);
      check("rst_frame_last", WinW'(out_frame_last), '0);
      m_col     = 0;
      m_row     = 0;
      exp_valid = 1'b0;
      exp_win   = '0;
      exp_rl    = 1'b0;
      exp_fl    = 1'b0;
      win_cnt   = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int target, budget;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_col    = '0;
      out_ready = 1'b1;
      apply_reset();

      // Partial row, then reset mid-row; next window must use fresh columns 0..2.
      repeat (5) step(1'b1, 1'b1);
      apply_reset();

      // One full frame at full throughput, then straight into a second frame.
      repeat (W * (H - K + 1)) step(1'b1, 1'b1);
      repeat (4) step(1'b1, 1'b1);
      repeat (4) step(1'b1, 1'b0);
      repeat (W * (H - K + 1) - 4) step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      // Random handshake over three frames.
      target = n_accepts + 3 * W * (H - K + 1);
      budget = 0;
      while (n_accepts < target && budget < 3000) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
         budget++;
      end
      check("random_accepts", WinW'(n_accepts), WinW'(target));
      repeat (3) step(1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
